// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the time-of-day core.
package clock_pkg;

    typedef logic [7:0] bcd8_t;

    localparam bcd8_t HOUR_MAX = 8'h23;
    localparam bcd8_t MS_MAX   = 8'h59;
    localparam bcd8_t NOON     = 8'h12;

    typedef struct packed {
        logic  pm;
        bcd8_t hour;
    } hour12_t;

    // Digit order matches numeric order once both digits are <= 9, so a plain compare bounds the value.
    function automatic logic bcd_valid(input bcd8_t v, input bcd8_t max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    function automatic bcd8_t bcd_next(input bcd8_t v, input bcd8_t max);
        bcd8_t r;
        if (v == max)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic hour12_t to_12h(input bcd8_t h24);
        hour12_t    r;
        logic [7:0] bin;
        bin    = 8'(h24[7:4]) * 8'd10 + 8'(h24[3:0]);
        r.pm   = 1'b0;
        r.hour = h24;
        if (h24 == 8'h00) begin
            r.hour = NOON;
        end else if (h24 == NOON) begin
            r.pm = 1'b1;
        end else if (h24 > NOON) begin
            bin    = bin - 8'd12;
            r.pm   = 1'b1;
            r.hour = {4'(bin / 8'd10), 4'(bin % 8'd10)};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter wrapping at MAX; load has priority over increment.
module bcd_wrap_counter
    import clock_pkg::*;
#(
    parameter bcd8_t MAX = 8'h59
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] q,
    output logic       carry
);

    // Combinational so the next digit pair up the chain steps in the same edge.
    assign carry = inc && (q == MAX);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= 8'h00;
        else if (load)
            q <= load_val;
        else if (inc)
            q <= bcd_next(q, MAX);
    end

endmodule

// File: rtl/tod_counter_fmt.sv
// Settable BCD time-of-day counter with 12/24h display formatting and hour:minute alarms.
module tod_counter_fmt
    import clock_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int NUM_ALARMS = 2
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    mode,
    input  logic                    set_valid,
    output logic                    set_ready,
    input  logic [7:0]              set_hour,
    input  logic [7:0]              set_min,
    input  logic [7:0]              set_sec,
    output logic                    set_err,
    input  logic [8*NUM_ALARMS-1:0] alarm_hour,
    input  logic [8*NUM_ALARMS-1:0] alarm_min,
    input  logic [NUM_ALARMS-1:0]   alarm_en,
    output logic [7:0]              hour24,
    output logic [7:0]              min,
    output logic [7:0]              sec,
    output logic [7:0]              show_hour,
    output logic                    show_pm,
    output logic [NUM_ALARMS-1:0]   alarm_hit,
    output logic                    day_carry
);

    localparam logic [9:0] PRESC_LAST = 10'(TICK_DIV - 1);

    logic [9:0]            presc;
    logic                  set_acc;
    logic                  set_ok;
    logic                  load;
    logic                  step;
    logic                  sec_carry;
    logic                  min_carry;
    logic                  hour_carry;
    bcd8_t                 min_next;
    bcd8_t                 hour_next;
    hour12_t               fmt;
    logic [NUM_ALARMS-1:0] hit_now;

    assign set_acc = set_valid && set_ready;
    assign set_ok  = bcd_valid(set_hour, HOUR_MAX) && bcd_valid(set_min, MS_MAX)
                  && bcd_valid(set_sec, MS_MAX);
    assign load    = set_acc && set_ok;
    // Any accepted set request, good or bad, swallows a coincident second step.
    assign step    = tick && !set_acc && (presc == PRESC_LAST);

    bcd_wrap_counter #(.MAX(MS_MAX)) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (step),
        .load     (load),
        .load_val (set_sec),
        .q        (sec),
        .carry    (sec_carry)
    );

    bcd_wrap_counter #(.MAX(MS_MAX)) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (sec_carry),
        .load     (load),
        .load_val (set_min),
        .q        (min),
        .carry    (min_carry)
    );

    bcd_wrap_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (min_carry),
        .load     (load),
        .load_val (set_hour),
        .q        (hour24),
        .carry    (hour_carry)
    );

    assign min_next  = sec_carry ? bcd_next(min, MS_MAX) : min;
    assign hour_next = min_carry ? bcd_next(hour24, HOUR_MAX) : hour24;
    assign fmt       = to_12h(hour24);

    always_comb begin
        hit_now = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            hit_now[i] = alarm_en[i] && sec_carry
                      && bcd_valid(alarm_hour[8*i +: 8], HOUR_MAX)
                      && bcd_valid(alarm_min[8*i +: 8], MS_MAX)
                      && (alarm_hour[8*i +: 8] == hour_next)
                      && (alarm_min[8*i +: 8] == min_next);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc     <= '0;
            set_ready <= 1'b1;
            set_err   <= 1'b0;
            day_carry <= 1'b0;
            alarm_hit <= '0;
            show_hour <= 8'h00;
            show_pm   <= 1'b0;
        end else begin
            set_ready <= !set_acc;
            set_err   <= set_acc && !set_ok;
            day_carry <= hour_carry;
            alarm_hit <= hit_now;
            show_hour <= mode ? hour24 : fmt.hour;
            show_pm   <= !mode && fmt.pm;
            if (set_acc) begin
                if (set_ok)
                    presc <= '0;
            end else if (tick) begin
                presc <= (presc == PRESC_LAST) ? 10'd0 : presc + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_tod_counter_fmt.sv
// Directed bench: full-day count, 12h formatting table, set errors, prescaler/set race, alarms.
module tb_tod_counter_fmt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, tick, mode, sv_a, sv_b;
    logic [7:0]  s_hour, s_min, s_sec;
    logic [15:0] al_hour, al_min;
    logic [1:0]  al_en;

    logic       rdy_a, err_a, pm_a, dc_a;
    logic [7:0] h_a, m_a, s_a, sh_a;
    logic [1:0] hit_a;
    logic       rdy_b, err_b, pm_b, dc_b;
    logic [7:0] h_b, m_b, s_b, sh_b;
    logic [1:0] hit_b;

    int checks   = 0;
    int failures = 0;

    tod_counter_fmt #(.TICK_DIV(1), .NUM_ALARMS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode),
        .set_valid(sv_a), .set_ready(rdy_a),
        .set_hour(s_hour), .set_min(s_min), .set_sec(s_sec), .set_err(err_a),
        .alarm_hour(al_hour), .alarm_min(al_min), .alarm_en(al_en),
        .hour24(h_a), .min(m_a), .sec(s_a), .show_hour(sh_a), .show_pm(pm_a),
        .alarm_hit(hit_a), .day_carry(dc_a)
    );

    tod_counter_fmt #(.TICK_DIV(4), .NUM_ALARMS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode),
        .set_valid(sv_b), .set_ready(rdy_b),
        .set_hour(s_hour), .set_min(s_min), .set_sec(s_sec), .set_err(err_b),
        .alarm_hour(al_hour), .alarm_min(al_min), .alarm_en(al_en),
        .hour24(h_b), .min(m_b), .sec(s_b), .show_hour(sh_b), .show_pm(pm_b),
        .alarm_hit(hit_b), .day_carry(dc_b)
    );

    typedef struct {
        logic       mode;
        logic [7:0] hour;
        logic [7:0] exp_show;
        logic       exp_pm;
    } fmt_vec_t;

    fmt_vec_t vecs[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        s_hour = h;
        s_min  = m;
        s_sec  = s;
        sv_a   = 1'b1;
        step();
        sv_a   = 1'b0;
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    initial begin
        int errs;
        int dcs;

        vecs[0]  = '{1'b0, 8'h00, 8'h12, 1'b0};
        vecs[1]  = '{1'b0, 8'h01, 8'h01, 1'b0};
        vecs[2]  = '{1'b0, 8'h02, 8'h02, 1'b0};
        vecs[3]  = '{1'b0, 8'h03, 8'h03, 1'b0};
        vecs[4]  = '{1'b0, 8'h04, 8'h04, 1'b0};
        vecs[5]  = '{1'b0, 8'h05, 8'h05, 1'b0};
        vecs[6]  = '{1'b0, 8'h06, 8'h06, 1'b0};
        vecs[7]  = '{1'b0, 8'h07, 8'h07, 1'b0};
        vecs[8]  = '{1'b0, 8'h08, 8'h08, 1'b0};
        vecs[9]  = '{1'b0, 8'h09, 8'h09, 1'b0};
        vecs[10] = '{1'b0, 8'h10, 8'h10, 1'b0};
        vecs[11] = '{1'b0, 8'h11, 8'h11, 1'b0};
        vecs[12] = '{1'b0, 8'h12, 8'h12, 1'b1};
        vecs[13] = '{1'b0, 8'h13, 8'h01, 1'b1};
        vecs[14] = '{1'b0, 8'h14, 8'h02, 1'b1};
        vecs[15] = '{1'b0, 8'h15, 8'h03, 1'b1};
        vecs[16] = '{1'b0, 8'h16, 8'h04, 1'b1};
        vecs[17] = '{1'b0, 8'h17, 8'h05, 1'b1};
        vecs[18] = '{1'b0, 8'h18, 8'h06, 1'b1};
        vecs[19] = '{1'b0, 8'h19, 8'h07, 1'b1};
        vecs[20] = '{1'b0, 8'h20, 8'h08, 1'b1};
        vecs[21] = '{1'b0, 8'h21, 8'h09, 1'b1};
        vecs[22] = '{1'b0, 8'h22, 8'h10, 1'b1};
        vecs[23] = '{1'b0, 8'h23, 8'h11, 1'b1};
        vecs[24] = '{1'b1, 8'h20, 8'h20, 1'b0};
        vecs[25] = '{1'b1, 8'h00, 8'h00, 1'b0};

        rst_n = 1'b0; tick = 1'b0; mode = 1'b1; sv_a = 1'b0; sv_b = 1'b0;
        s_hour = 8'h00; s_min = 8'h00; s_sec = 8'h00;
        al_hour = 16'h0000; al_min = 16'h0000; al_en = 2'b00;
        step();
        step();

        chk("rst_time", {h_a, m_a, s_a}, 24'h000000);
        chk("rst_show", {sh_a, pm_a}, 9'h000);
        chk("rst_flags", {rdy_a, err_a, hit_a, dc_a}, 5'b10000);
        chk("rst_flags_b", {rdy_b, err_b, hit_b, dc_b, h_b}, 13'b1000_0000_0000_0);

        // Full day at one tick per second.
        rst_n = 1'b1;
        tick  = 1'b1;
        errs  = 0;
        dcs   = 0;
        for (int k = 1; k <= 86399; k++) begin
            step();
            if ({h_a, m_a, s_a} !== {to_bcd(k / 3600), to_bcd((k / 60) % 60), to_bcd(k % 60)})
                errs++;
            if (dc_a) dcs++;
        end
        chk("day_sweep_errors", errs, 0);
        chk("at_235959", {h_a, m_a, s_a}, 24'h235959);
        chk("show24_lag", {sh_a, pm_a}, {8'h23, 1'b0});
        step();
        if (dc_a) dcs++;
        chk("wrap_000000", {h_a, m_a, s_a}, 24'h000000);
        chk("day_carry_on_wrap", dc_a, 1'b1);
        tick = 1'b0;
        step();
        chk("day_carry_one_cycle", dc_a, 1'b0);
        chk("day_carry_count", dcs, 1);

        // 11:59:59 -> 12:00:00 in 12h mode, formatter one cycle behind.
        mode = 1'b0;
        set_a(8'h11, 8'h59, 8'h59);
        step();
        chk("pre_noon_show", {sh_a, pm_a}, {8'h11, 1'b0});
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("noon_hour24", {h_a, m_a, s_a}, 24'h120000);
        chk("noon_show_lag", {sh_a, pm_a}, {8'h11, 1'b0});
        step();
        chk("noon_show", {sh_a, pm_a}, {8'h12, 1'b1});

        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            set_a(vecs[i].hour, 8'h00, 8'h00);
            step();
            if ({sh_a, pm_a} !== {vecs[i].exp_show, vecs[i].exp_pm}) begin
                $display("FAIL fmt_vec[%0d] hour=%h mode=%0d: got %h/%0d expected %h/%0d",
                         i, vecs[i].hour, vecs[i].mode, sh_a, pm_a, vecs[i].exp_show, vecs[i].exp_pm);
                failures++;
            end
            checks++;
        end

        // Rejected sets.
        set_a(8'h10, 8'h20, 8'h30);
        step();
        set_a(8'h24, 8'h00, 8'h00);
        chk("bad_hour_err", {err_a, rdy_a}, 2'b10);
        chk("bad_hour_time", {h_a, m_a, s_a}, 24'h102030);
        step();
        chk("bad_hour_recover", {err_a, rdy_a}, 2'b01);
        set_a(8'h10, 8'h6A, 8'h00);
        chk("bad_min_err", {err_a, rdy_a}, 2'b10);
        chk("bad_min_time", {h_a, m_a, s_a}, 24'h102030);
        step();
        chk("bad_min_recover", {err_a, rdy_a}, 2'b01);

        // Reset beats a coincident tick and set.
        rst_n = 1'b0; tick = 1'b1;
        s_hour = 8'h12; s_min = 8'h00; s_sec = 8'h00; sv_a = 1'b1;
        step();
        sv_a = 1'b0; tick = 1'b0;
        chk("rst_override", {h_a, m_a, s_a, rdy_a}, {24'h000000, 1'b1});
        rst_n = 1'b1;

        // TICK_DIV=4: set coinciding with the 4th tick.
        tick = 1'b1;
        step(); step(); step();
        s_hour = 8'h08; s_min = 8'h30; s_sec = 8'h00; sv_b = 1'b1;
        step();
        sv_b = 1'b0;
        chk("div4_set_wins", {h_b, m_b, s_b}, 24'h083000);
        step(); step(); step();
        chk("div4_no_step_yet", {h_b, m_b, s_b}, 24'h083000);
        step();
        chk("div4_step", {h_b, m_b, s_b}, 24'h083001);
        tick = 1'b0;

        // Alarms.
        mode = 1'b1;
        al_hour = {8'h07, 8'h07};
        al_min  = {8'h00, 8'h00};
        al_en   = 2'b01;
        set_a(8'h06, 8'h59, 8'h59);
        step();
        chk("alarm_idle", hit_a, 2'b00);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("alarm_ch0", {hit_a, h_a, m_a, s_a}, {2'b01, 24'h070000});
        step();
        chk("alarm_one_cycle", hit_a, 2'b00);
        al_en = 2'b11;
        set_a(8'h06, 8'h59, 8'h59);
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("alarm_both", hit_a, 2'b11);
        step();
        set_a(8'h07, 8'h00, 8'h00);
        chk("alarm_set_no_hit", hit_a, 2'b00);
        step();
        chk("alarm_set_no_hit2", hit_a, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
